serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` for two W-bit operands, one bit per clock, LSB first. Each cycle applies the half-subtractor equations (`diff = x ^ y`, `borrow = ~x & y`) extended with a registered borrow, forming a sequential full-subtract stage. It sits directly downstream of the combinational half-subtractor cell, chaining borrow across cycles instead of across instances. It trades area for latency in multi-bit subtraction paths.

## Interface

Parameters:
- `W`, default 8: operand and result width in bits. Legal range is W >= 1.

Ports:
- `clk`, input, 1 bit: single clock. All state changes on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `start`, input, 1 bit: request. Sampled on a rising edge in IDLE or DONE.
- `a`, input, W bits: minuend. Captured only when start is accepted.
- `b`, input, W bits: subtrahend. Captured only when start is accepted.
- `busy`, output, 1 bit: high while in RUN.
- `done`, output, 1 bit: one-cycle completion pulse.
- `diff`, output, W bits: result. Held until the next completion.
- `borrow`, output, 1 bit: final borrow out. 1 means a < b.

## Operation

- States:
  - IDLE: reset state.
  - RUN: subtraction in progress.
  - DONE: one-cycle completion state.
- Reset values: state=IDLE; `busy`=0, `done`=0, `diff`=0, `borrow`=0. Internal shift registers, bit counter and borrow register are also 0.
- IDLE or DONE with `start`=1:
  - Load `a` and `b` into internal shift registers.
  - Clear the borrow register and the bit counter to 0.
  - Go to RUN.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle, with x = LSB of the a-register and y = LSB of the b-register:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
  - Shift both operand registers right by one.
  - Shift d into the MSB of the internal result register, which shifts right.
  - Increment the counter.
- When the counter reaches W-1 in RUN:
  - On that edge, write the completed result to `diff` and br_next to `borrow`.
  - Go to DONE.
- Arithmetic: result = (a - b) mod 2^W; `borrow` = 1 exactly when a < b (unsigned).
- `diff` and `borrow` do not change during RUN. They update only on the edge entering DONE.
- `start` asserted in RUN is ignored and not queued.
- W=1: a single RUN cycle; `diff` = a ^ b and `borrow` = ~a & b.

## Timing

- `start` accepted at rising edge E0:
  - `busy`=1 from E0 to E0+W, i.e. exactly W cycles.
  - At edge E0+W: `busy` falls, `done`=1 and new `diff`/`borrow` are visible.
  - At edge E0+W+1: `done` falls.
- Latency from start accept to done: W cycles.
- Back-to-back operation: `start` high during the DONE cycle is accepted at E0+W+1, with no idle gap. Minimum issue interval is W+1 cycles.
- `start` held permanently high gives one result every W+1 cycles.
- Reset asserted at any time, including mid-RUN:
  - All outputs go to their reset values immediately (asynchronously).
  - The partial result is discarded and no `done` pulse is issued.
  - The first edge after `rst` deasserts behaves as IDLE.

## Configuration

- `SERIAL_SUB_SAT_EN` defined: saturating mode. If the final borrow is 1, `diff` is written as all zeros. `borrow` still reports 1. Timing is unchanged.
- `SERIAL_SUB_SAT_EN` undefined: wrap-around mode. `diff` = (a - b) mod 2^W.

## Test plan

- Reset mid-RUN:
  - W=8; start with a=200, b=55; assert `rst` 3 cycles later.
  - Required: `busy`, `done`, `diff`, `borrow` all 0 immediately, and no `done` pulse afterwards.
  - After release, the same request returns `diff`=145 and `borrow`=0.
- Basic subtract and latency:
  - W=8, a=200, b=55.
  - Required: `busy` high for exactly 8 cycles, then a 1-cycle `done` with `diff`=0x91 and `borrow`=0.
  - Required: `diff` holds its previous value throughout RUN.
- Underflow:
  - W=8, a=5, b=9. Without the macro: `diff`=0xFC, `borrow`=1. With `SERIAL_SUB_SAT_EN`: `diff`=0x00, `borrow`=1.
  - W=8, a=0x00, b=0xFF. Without the macro: `diff`=0x01, `borrow`=1.
- Equal operands: a=b=0xFF gives `diff`=0x00, `borrow`=0.
- Handshake:
  - `start` pulsed during RUN: ignored, and the operands in flight are unaffected.
  - `start` held high continuously with a/b changing each result: `done` pulses every 9 cycles (W=8), each carrying the operands sampled at its own accept edge.
- Exhaustive small width: W=2, all 16 (a,b) pairs against (a-b) mod 4 and the a<b borrow. Also W=1, all 4 pairs.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, a - b, LSB first.
// Each RUN cycle applies one full-subtract step (half-subtractor plus a
// registered borrow). The result and final borrow are published on the edge
// that enters DONE and are held until the next completion.
// Optional build macro: SERIAL_SUB_SAT_EN
//   defined   -> saturating mode: a final borrow of 1 writes diff as all zeros
//   undefined -> wrap-around mode: diff = (a - b) mod 2^W
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // Counter must hold 0..W-1; keep at least one bit for W=1.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   res_sh;
  logic [CW-1:0]  cnt;
  logic           br;

  logic           x;
  logic           y;
  logic           d;
  logic           br_next;
  logic           last;
  logic [W-1:0]   res_next;
  logic [W-1:0]   diff_final;

  // One full-subtract step on the current operand LSBs plus the stored borrow.
  always_comb begin
    x          = a_sh[0];
    y          = b_sh[0];
    d          = x ^ y ^ br;
    br_next    = (~x & y) | (~(x ^ y) & br);
    // Result register shifts right; the new bit enters at the MSB so that
    // after W steps bit 0 of the result sits at bit 0.
    res_next   = res_sh >> 1'b1;
    res_next[W-1] = d;
    last       = (cnt == CW'(W - 1));
`ifdef SERIAL_SUB_SAT_EN
    if (br_next) begin
      diff_final = '0;
    end else begin
      diff_final = res_next;
    end
`else
    diff_final = res_next;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE or DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (last)  state_next = DONE;
        else       state_next = RUN;
      end
      DONE: begin
        if (start) state_next = RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand capture, serial shifting, and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1'b1;
          b_sh   <= b_sh >> 1'b1;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          br     <= br_next;
          // diff/borrow stay frozen during RUN and change only here.
          if (last) begin
            diff   <= diff_final;
            borrow <= br_next;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: W=8 directed and random
// operations, back-to-back issue, reset mid-RUN, and exhaustive W=2 / W=1.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  logic       start8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;

  logic       start2, busy2, done2, borrow2;
  logic [1:0] a2, b2, diff2;

  logic       start1, busy1, done1, borrow1;
  logic [0:0] a1, b1, diff1;

  int n_tests;
  int n_fail;
  logic [7:0] last_diff8;

  serial_subtractor #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
  );

  serial_subtractor #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain modular arithmetic on the operand values.
  function automatic int unsigned ref_diff(input int unsigned x, input int unsigned y, input int w);
    int unsigned m;
    int unsigned r;
    m = 32'd1 << w;
    r = (x + m - y) % m;
`ifdef SERIAL_SUB_SAT_EN
    if (x < y) r = 32'd0;
`endif
    return r;
  endfunction

  function automatic int unsigned ref_borrow(input int unsigned x, input int unsigned y);
    return (x < y) ? 32'd1 : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One W=8 operation with full cycle-by-cycle checking; optional start pulse
  // (with scrambled operands) in the middle of RUN.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input bit pulse);
    int unsigned ed;
    int unsigned eb;
    ed = ref_diff(32'(av), 32'(bv), 8);
    eb = ref_borrow(32'(av), 32'(bv));
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy_rise", 32'(busy8), 32'd1);
    check("done_low_run", 32'(done8), 32'd0);
    for (int i = 1; i < 8; i++) begin
      if (pulse && i == 3) begin
        start8 = 1'b1; a8 = ~av; b8 = ~bv;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      check("busy_run", 32'(busy8), 32'd1);
      check("done_run", 32'(done8), 32'd0);
      check("diff_held", 32'(diff8), 32'(last_diff8));
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    check("busy_fall", 32'(busy8), 32'd0);
    check("done_pulse", 32'(done8), 32'd1);
    check("diff", 32'(diff8), ed);
    check("borrow", 32'(borrow8), eb);
    @(posedge clk); #1;
    check("done_fall", 32'(done8), 32'd0);
    check("busy_idle", 32'(busy8), 32'd0);
    last_diff8 = 8'(ed);
  endtask

  initial begin
    logic [7:0] qa [5];
    logic [7:0] qb [5];
    n_tests = 0; n_fail = 0; last_diff8 = 8'd0;
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(borrow8), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic subtract with latency, then the fixed-value cases.
    do_op8(8'd200, 8'd55, 1'b0);
    check("basic_0x91", 32'(diff8), 32'h91);
    do_op8(8'd5, 8'd9, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
    check("under_sat", 32'(diff8), 32'h00);
`else
    check("under_wrap", 32'(diff8), 32'hFC);
`endif
    do_op8(8'h00, 8'hFF, 1'b0);
    do_op8(8'hFF, 8'hFF, 1'b0);
    check("equal_zero", 32'(diff8), 32'h00);

    // start pulsed during RUN must not disturb the operation in flight.
    do_op8(8'd77, 8'd130, 1'b1);
    do_op8(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b1);

    // Random operations.
    for (int k = 0; k < 20; k++) begin
      do_op8(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
    end

    // start held high: one result every 9 cycles, each from its own accept edge.
    for (int k = 0; k < 5; k++) begin
      qa[k] = 8'($urandom_range(255, 0));
      qb[k] = 8'($urandom_range(255, 0));
    end
    @(negedge clk);
    a8 = qa[0]; b8 = qb[0]; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = qa[1]; b8 = qb[1];
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (c % 9 == 8) begin
        check("b2b_done", 32'(done8), 32'd1);
        check("b2b_diff", 32'(diff8), ref_diff(32'(qa[c / 9]), 32'(qb[c / 9]), 8));
        check("b2b_borrow", 32'(borrow8), ref_borrow(32'(qa[c / 9]), 32'(qb[c / 9])));
      end else begin
        check("b2b_nodone", 32'(done8), 32'd0);
      end
      if (c % 9 == 0) begin
        a8 = qa[c / 9 + 1]; b8 = qb[c / 9 + 1];
      end
      if (c == 35) start8 = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b_idle", 32'(busy8), 32'd0);
    last_diff8 = 8'(ref_diff(32'(qa[3]), 32'(qb[3]), 8));

    // Reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_diff", 32'(diff8), 32'd0);
    check("mid_rst_borrow", 32'(borrow8), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_nodone", 32'(done8), 32'd0);
    end
    last_diff8 = 8'd0;
    do_op8(8'd200, 8'd55, 1'b0);
    check("post_rst_145", 32'(diff8), 32'd145);

    // Exhaustive W=2.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        @(negedge clk);
        a2 = 2'(x); b2 = 2'(y); start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("w2_done", 32'(done2), 32'd1);
        check("w2_diff", 32'(diff2), ref_diff(32'(x), 32'(y), 2));
        check("w2_borrow", 32'(borrow2), ref_borrow(32'(x), 32'(y)));
      end
    end

    // Exhaustive W=1.
    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        @(negedge clk);
        a1 = 1'(x); b1 = 1'(y); start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("w1_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        check("w1_done", 32'(done1), 32'd1);
        check("w1_diff", 32'(diff1), ref_diff(32'(x), 32'(y), 1));
        check("w1_borrow", 32'(borrow1), ref_borrow(32'(x), 32'(y)));
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
